// File: rtl/fxp_addsub_sm_if.sv
// fxp_addsub_sm_if: start/busy/done operand and result bundle for fxp_addsub_sm
interface fxp_addsub_sm_if #(parameter int WIDTH = 16);
  logic start, sub, busy, done, ovf;
  logic [WIDTH-1:0] x, y, result;
  modport master(output start, sub, x, y, input busy, done, result, ovf);
  modport slave(input start, sub, x, y, output busy, done, result, ovf);
endinterface

// File: rtl/fxp_addsub_sm.sv
// fxp_addsub_sm: sign-magnitude add/sub, 4-cycle start/busy/done, saturate or wrap on overflow
module fxp_addsub_sm #(
  parameter int WIDTH = 16,
  parameter bit SATURATE = 1
) (
  input logic clk,
  input logic rst,
  fxp_addsub_sm_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, ADD, SAT} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] xr, yr;
  logic sub_r, s_neg, ovf_c;
  logic [WIDTH:0] ca, cb, sum, s_abs;
  logic [WIDTH-2:0] o_mag;
  function automatic logic [WIDTH:0] to_tc(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] m;
    m = {2'b00, v[WIDTH-2:0]};
    return v[WIDTH-1] ? -m : m;
  endfunction
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (bus.start ? CONV : IDLE) :
                state == CONV ? ADD : state == ADD ? SAT : IDLE;
    s_neg = sum[WIDTH];
    s_abs = s_neg ? -sum : sum;
    ovf_c = |s_abs[WIDTH:WIDTH-1];
    o_mag = (ovf_c && SATURATE) ? '1 : s_abs[WIDTH-2:0];
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      xr <= '0;
      yr <= '0;
      sub_r <= 1'b0;
      ca <= '0;
      cb <= '0;
      sum <= '0;
      bus.done <= 1'b0;
      bus.result <= '0;
      bus.ovf <= 1'b0;
    end else begin
      bus.done <= state == SAT;
      if (state == IDLE && bus.start) begin
        xr <= bus.x;
        yr <= bus.y;
        sub_r <= bus.sub;
      end
      if (state == CONV) begin
        ca <= to_tc(xr);
        cb <= sub_r ? -to_tc(yr) : to_tc(yr);
      end
      if (state == ADD) sum <= ca + cb;
      // a zero magnitude always leaves with a positive sign
      if (state == SAT) begin
        bus.result <= {s_neg && |o_mag, o_mag};
        bus.ovf <= ovf_c;
      end
    end
endmodule

// File: tb/tb_fxp_addsub_sm.sv
// tb_fxp_addsub_sm: scoreboard bench over 16/sat, 16/wrap and 8/sat instances
module tb_fxp_addsub_sm;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0] st = '0, dn, bz, ov;
  logic [15:0] x = '0, y = '0;
  logic sub = 1'b0;
  logic [15:0] res [3];
  logic [16:0] sb_q [$];
  int n_chk = 0, n_fail = 0;

  fxp_addsub_sm_if #(.WIDTH(16)) ia();
  fxp_addsub_sm_if #(.WIDTH(16)) ib();
  fxp_addsub_sm_if #(.WIDTH(8)) ic();
  fxp_addsub_sm #(.WIDTH(16), .SATURATE(1)) dut_a(.clk(clk), .rst(rst), .bus(ia));
  fxp_addsub_sm #(.WIDTH(16), .SATURATE(0)) dut_b(.clk(clk), .rst(rst), .bus(ib));
  fxp_addsub_sm #(.WIDTH(8), .SATURATE(1)) dut_c(.clk(clk), .rst(rst), .bus(ic));

  assign ia.start = st[0];
  assign ib.start = st[1];
  assign ic.start = st[2];
  assign ia.x = x;
  assign ib.x = x;
  assign ic.x = x[7:0];
  assign ia.y = y;
  assign ib.y = y;
  assign ic.y = y[7:0];
  assign ia.sub = sub;
  assign ib.sub = sub;
  assign ic.sub = sub;
  assign dn = {ic.done, ib.done, ia.done};
  assign bz = {ic.busy, ib.busy, ia.busy};
  assign ov = {ic.ovf, ib.ovf, ia.ovf};
  assign res[0] = ia.result;
  assign res[1] = ib.result;
  assign res[2] = {8'h00, ic.result};

  // reference built from integer arithmetic: {ovf, result}
  function automatic logic [16:0] model(int w, bit sat, logic [15:0] a, logic [15:0] b, bit s);
    int mx, va, vb, sm, m;
    logic [31:0] r;
    bit o;
    mx = (1 << (w - 1)) - 1;
    va = int'(a) & mx;
    vb = int'(b) & mx;
    if (a[w-1]) va = -va;
    if (b[w-1]) vb = -vb;
    if (s) vb = -vb;
    sm = va + vb;
    m = sm < 0 ? -sm : sm;
    o = m > mx;
    if (o) m = sat ? mx : (m & mx);
    r = (sm < 0 && m != 0) ? (m | (1 << (w - 1))) : m;
    return {o, r[15:0]};
  endfunction

  task automatic run(input int d, input logic [15:0] xi, input logic [15:0] yi, input logic si,
                     output logic [15:0] r, output logic o, output int lat);
    @(negedge clk);
    x = xi;
    y = yi;
    sub = si;
    st[d] = 1'b1;
    @(posedge clk);
    #1;
    st[d] = 1'b0;
    x = 16'($urandom);
    y = 16'($urandom);
    sub = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!dn[d] && lat < 10);
    r = res[d];
    o = ov[d];
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bz, dn, ov} !== 9'b0 || res[0] !== 16'h0 || res[1] !== 16'h0 || res[2] !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b ovf=%b res=%h/%h/%h, want all zero", bz, dn, ov, res[0], res[1], res[2]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [15:0] r, xi, yi;
    logic o, si;
    int lat;
    logic [16:0] e;
    for (int i = 0; i < 9; i++) begin
      xi = i == 0 ? 16'h3400 : 16'($urandom);
      yi = i == 0 ? 16'h8400 : 16'($urandom);
      si = i == 0 ? 1'b0 : 1'($urandom);
      sb_q.push_back(i == 0 ? {1'b0, 16'h3000} : model(16, 1, xi, yi, si));
      run(0, xi, yi, si, r, o, lat);
      e = sb_q.pop_front();
      n_chk++;
      if ({o, r} !== e || lat != 3) begin
        n_fail++;
        $display("FAIL add[%0d] %h %h sub=%0b: ovf=%0b res=%h lat=%0d, want ovf=%0b res=%h lat=3", i, xi, yi, si, o, r, lat, e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [15:0] xs [3] = '{16'h7FFF, 16'hFFFF, 16'h7FFF};
    logic [15:0] ys [3] = '{16'h0001, 16'h8001, 16'h0001};
    logic [16:0] es [3] = '{{1'b1, 16'h7FFF}, {1'b1, 16'hFFFF}, {1'b1, 16'h0000}};
    int ds [3] = '{0, 0, 1};
    logic [15:0] r, xi, yi;
    logic o, si;
    int lat, d;
    logic [16:0] e;
    for (int i = 0; i < 7; i++) begin
      d = i < 3 ? ds[i] : 1;
      xi = i < 3 ? xs[i] : 16'($urandom);
      yi = i < 3 ? ys[i] : 16'($urandom);
      si = i < 3 ? 1'b0 : 1'($urandom);
      sb_q.push_back(i < 3 ? es[i] : model(16, 0, xi, yi, si));
      run(d, xi, yi, si, r, o, lat);
      e = sb_q.pop_front();
      n_chk++;
      if ({o, r} !== e || lat != 3) begin
        n_fail++;
        $display("FAIL ovf[%0d] dut%0d %h %h sub=%0b: ovf=%0b res=%h lat=%0d, want ovf=%0b res=%h lat=3", i, d, xi, yi, si, o, r, lat, e[16], e[15:0]);
      end
    end
  endtask

  task automatic test_sub_negzero();
    logic [15:0] xs [4] = '{16'h8005, 16'h0005, 16'h8000, 16'h8000};
    logic [15:0] ys [4] = '{16'h0003, 16'h0005, 16'h8000, 16'h0007};
    logic ss [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [16:0] es [4] = '{{1'b0, 16'h8008}, {1'b0, 16'h0000}, {1'b0, 16'h0000}, {1'b0, 16'h8007}};
    logic [15:0] r, xi, yi;
    logic o, si;
    int lat, d;
    logic [16:0] e;
    for (int i = 0; i < 10; i++) begin
      d = i < 4 ? 0 : 2;
      xi = i < 4 ? xs[i] : (i == 4 ? 16'h0080 : 16'($urandom_range(255)));
      yi = i < 4 ? ys[i] : (i == 4 ? 16'h0080 : 16'($urandom_range(255)));
      si = i < 4 ? ss[i] : 1'($urandom);
      sb_q.push_back(i < 4 ? es[i] : model(8, 1, xi, yi, si));
      run(d, xi, yi, si, r, o, lat);
      e = sb_q.pop_front();
      n_chk++;
      if ({o, r} !== e || lat != 3) begin
        n_fail++;
        $display("FAIL sub[%0d] dut%0d %h %h sub=%0b: ovf=%0b res=%h lat=%0d, want ovf=%0b res=%h lat=3", i, d, xi, yi, si, o, r, lat, e[16], e[15:0]);
      end
    end
  endtask

  // start held high with operands changing every cycle: accepts land on every 4th edge
  task automatic test_back_to_back();
    logic [15:0] last;
    logic [16:0] e;
    @(negedge clk);
    last = res[0];
    st[0] = 1'b1;
    for (int k = 0; k < 24; k++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      sub = 1'($urandom);
      if (k % 4 == 0) sb_q.push_back(model(16, 1, x, y, sub));
      @(posedge clk);
      #1;
      n_chk++;
      if (bz[0] !== (k % 4 != 3) || dn[0] !== (k % 4 == 3)) begin
        n_fail++;
        $display("FAIL b2b hs edge %0d: busy=%b done=%b, want busy=%b done=%b", k, bz[0], dn[0], k % 4 != 3, k % 4 == 3);
      end
      if (k % 4 == 3) begin
        e = sb_q.pop_front();
        n_chk++;
        if ({ov[0], res[0]} !== e) begin
          n_fail++;
          $display("FAIL b2b result edge %0d: ovf=%0b res=%h, want ovf=%0b res=%h", k, ov[0], res[0], e[16], e[15:0]);
        end
        last = res[0];
      end else begin
        n_chk++;
        if (res[0] !== last) begin
          n_fail++;
          $display("FAIL b2b hold edge %0d: res=%h, want %h", k, res[0], last);
        end
      end
      @(negedge clk);
    end
    st[0] = 1'b0;
  endtask

  task automatic test_reset_mid(input int d, input logic [15:0] xi, input logic [15:0] yi, input logic [16:0] e);
    logic [15:0] r;
    logic o;
    int lat, seen;
    @(negedge clk);
    x = xi;
    y = yi;
    sub = 1'b0;
    st[d] = 1'b1;
    @(posedge clk);
    #1;
    st[d] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (bz[d] !== 1'b0 || dn[d] !== 1'b0 || res[d] !== 16'h0 || ov[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid dut%0d: busy=%b done=%b res=%h ovf=%b, want 0 0 0000 0", d, bz[d], dn[d], res[d], ov[d]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (dn[d]) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_mid dut%0d: %0d done pulses after reset, want 0", d, seen);
    end
    sb_q.push_back(e);
    run(d, xi, yi, 1'b0, r, o, lat);
    e = sb_q.pop_front();
    n_chk++;
    if ({o, r} !== e || lat != 3) begin
      n_fail++;
      $display("FAIL rst_mid redo dut%0d: ovf=%0b res=%h lat=%0d, want ovf=%0b res=%h lat=3", d, o, r, lat, e[16], e[15:0]);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub_negzero();
    test_back_to_back();
    test_reset_mid(0, 16'h1234, 16'h0111, {1'b0, 16'h1345});
    test_reset_mid(2, 16'h007F, 16'h0001, {1'b1, 16'h007F});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
endmodule
